n64_vdemux: RTL and testbench

Input demultiplexer for the N64 video bus, placed directly behind the VCLK/nVDSYNC/D pins and ahead of the video-info extractor and pixel pipeline. It registers the 7-bit multiplexed bus and tracks the sync/R/G/B byte phase. Each sync byte is published as a current/previous 4-bit sync pair with an aligned active-low qualifier. Each complete pixel is emitted as one parallel word with a single-cycle valid strobe, and malformed byte sequences are flagged and counted.

---
 rtl/n64_vdemux_pkg.sv | 23 ++
 rtl/n64_vbus_reg.sv | 26 ++
 rtl/n64_vdemux.sv | 107 ++++++++++
 tb/tb_n64_vdemux.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/n64_vdemux_pkg.sv
// Shared N64 video-bus parameters: sync bit positions, colour width, phase FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a; the video bus is free-running and cannot be stalled.
package n64adv_vparams;

    // Sync nibble layout {nVSYNC, nCLAMP, nHSYNC, nCSYNC}, all active-low.
    localparam int SYNC_W    = 4;
    localparam int VSYNC_IDX = 3;
    localparam int CLAMP_IDX = 2;
    localparam int HSYNC_IDX = 1;
    localparam int CSYNC_IDX = 0;

    localparam int COLOR_WIDTH = 7;

    // Byte phase within a pixel. ST_WAIT means no pixel is in progress.
    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_SYNC = 2'd1,
        ST_R    = 2'd2,
        ST_G    = 2'd3
    } vphase_t;

endpackage

// File: rtl/n64_vbus_reg.sv
// Stage-0 input register for the multiplexed N64 video bus (qualifier plus data byte).
// Latency: 1 VCLK. Ports: clk, rst_n in; nvdsync, d in (raw pins); nvdsync_q, d_q out (registered).
// Backpressure: none; every edge samples the pins unconditionally.
module n64_vbus_reg #(
    parameter int color_width = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   nvdsync,
    input  logic [color_width-1:0] d,
    output logic                   nvdsync_q,
    output logic [color_width-1:0] d_q
);

    // Kept as its own instance so pad-side register placement can target it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nvdsync_q <= 1'b1;
            d_q       <= '0;
        end else begin
            nvdsync_q <= nvdsync;
            d_q       <= d;
        end
    end

endmodule

// File: rtl/n64_vdemux.sv
// N64 video-bus demultiplexer: tracks the sync/R/G/B byte phase and emits sync pairs and whole pixels.
// Latency: 2 VCLK from pin to Sync_cur_o/nVDSYNC_o, and from the B byte to vdata_o/vdata_valid_o.
// Backpressure: none; vdata_valid_o is a one-cycle strobe that downstream logic must take when it fires.
// Ports: VCLK, nRST (async, active-low), nVDSYNC/D_i raw bus in; nVDSYNC_o, Sync_pre_o, Sync_cur_o
//        sync view out; vdata_o/vdata_valid_o pixel out; phase_err_o/err_cnt_o malformed-pixel reporting.
module n64_vdemux
    import n64adv_vparams::*;
#(
    parameter int color_width = COLOR_WIDTH
) (
    input  logic                                VCLK,
    input  logic                                nRST,
    input  logic                                nVDSYNC,
    input  logic [color_width-1:0]              D_i,
    output logic                                nVDSYNC_o,
    output logic [SYNC_W-1:0]                   Sync_pre_o,
    output logic [SYNC_W-1:0]                   Sync_cur_o,
    output logic [SYNC_W+3*color_width-1:0]     vdata_o,
    output logic                                vdata_valid_o,
    output logic                                phase_err_o,
    output logic [7:0]                          err_cnt_o
);

    logic                   nvdsync_r;
    logic [color_width-1:0] d_r;

    n64_vbus_reg #(
        .color_width (color_width)
    ) u_vbus_reg (
        .clk       (VCLK),
        .rst_n     (nRST),
        .nvdsync   (nVDSYNC),
        .d         (D_i),
        .nvdsync_q (nvdsync_r),
        .d_q       (d_r)
    );

    vphase_t                state, state_nxt;
    logic [color_width-1:0] red_q, green_q;
    logic                   abort;

    // A sync byte always restarts the pixel; it only counts as an abort when
    // a pixel was already under way (not from ST_WAIT).
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        if (!nvdsync_r) begin
            state_nxt = ST_SYNC;
            abort     = (state != ST_WAIT);
        end else begin
            unique case (state)
                ST_SYNC: state_nxt = ST_R;
                ST_R:    state_nxt = ST_G;
                ST_G:    state_nxt = ST_WAIT;
                default: state_nxt = ST_WAIT;   // surplus data bytes are dropped silently
            endcase
        end
    end

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and reporting registers.
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            nVDSYNC_o     <= 1'b1;
            Sync_pre_o    <= '1;
            Sync_cur_o    <= '1;
            red_q         <= '0;
            green_q       <= '0;
            vdata_o       <= '0;
            vdata_valid_o <= 1'b0;
            phase_err_o   <= 1'b0;
            err_cnt_o     <= '0;
        end else begin
            // Qualifier moves with the sync registers so !nVDSYNC_o marks
            // exactly the cycle a new sync pair becomes visible.
            nVDSYNC_o     <= nvdsync_r;
            vdata_valid_o <= 1'b0;
            phase_err_o   <= abort;

            if (!nvdsync_r) begin
                Sync_pre_o <= Sync_cur_o;
                Sync_cur_o <= d_r[SYNC_W-1:0];
                if (abort && (err_cnt_o != 8'hFF)) begin
                    err_cnt_o <= err_cnt_o + 8'd1;
                end
            end else begin
                unique case (state)
                    ST_SYNC: red_q   <= d_r;
                    ST_R:    green_q <= d_r;
                    ST_G: begin
                        vdata_o       <= {Sync_cur_o, red_q, green_q, d_r};
                        vdata_valid_o <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_n64_vdemux.sv
module tb_n64_vdemux;

    logic        VCLK;
    logic        nRST;
    logic        nVDSYNC;
    logic [6:0]  D_i;
    logic        nVDSYNC_o;
    logic [3:0]  Sync_pre_o;
    logic [3:0]  Sync_cur_o;
    logic [24:0] vdata_o;
    logic        vdata_valid_o;
    logic        phase_err_o;
    logic [7:0]  err_cnt_o;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int err_pulses = 0;

    n64_vdemux #(.color_width(7)) dut (
        .VCLK          (VCLK),
        .nRST          (nRST),
        .nVDSYNC       (nVDSYNC),
        .D_i           (D_i),
        .nVDSYNC_o     (nVDSYNC_o),
        .Sync_pre_o    (Sync_pre_o),
        .Sync_cur_o    (Sync_cur_o),
        .vdata_o       (vdata_o),
        .vdata_valid_o (vdata_valid_o),
        .phase_err_o   (phase_err_o),
        .err_cnt_o     (err_cnt_o)
    );

    initial VCLK = 1'b0;
    always #5 VCLK = ~VCLK;

    // Count strobe cycles away from the active edge.
    always @(negedge VCLK) begin
        if (vdata_valid_o === 1'b1) valid_cnt++;
        if (phase_err_o === 1'b1) err_pulses++;
    end

    // Drive one bus byte just after an edge; it is sampled on the next edge.
    // On return, outputs reflect the byte driven two calls earlier.
    task automatic step(input logic nv, input logic [6:0] d);
        @(posedge VCLK);
        #1;
        nVDSYNC = nv;
        D_i     = d;
    endtask

    task automatic flush();
        for (int i = 0; i < 6; i++) step(1'b1, 7'h00);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge VCLK);
        #1;
        checks++; if (nVDSYNC_o !== 1'b1) begin errors++; $display("FAIL rst_nvdsync got %b want 1", nVDSYNC_o); end
        checks++; if (Sync_pre_o !== 4'hF) begin errors++; $display("FAIL rst_sync_pre got %h want f", Sync_pre_o); end
        checks++; if (Sync_cur_o !== 4'hF) begin errors++; $display("FAIL rst_sync_cur got %h want f", Sync_cur_o); end
        checks++; if (vdata_o !== 25'h0) begin errors++; $display("FAIL rst_vdata got %h want 0", vdata_o); end
        checks++; if (vdata_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", vdata_valid_o); end
        checks++; if (phase_err_o !== 1'b0) begin errors++; $display("FAIL rst_phase_err got %b want 0", phase_err_o); end
        checks++; if (err_cnt_o !== 8'h00) begin errors++; $display("FAIL rst_err_cnt got %h want 0", err_cnt_o); end
        @(negedge VCLK);
        nRST = 1'b1;
    endtask

    task automatic test_pixel();
        int v0, p0;
        logic [24:0] exp;
        v0 = valid_cnt; p0 = err_pulses;
        exp = {4'hF, 7'h11, 7'h22, 7'h33};
        step(1'b0, 7'h0F);
        step(1'b1, 7'h11);
        step(1'b1, 7'h22);
        checks++; if (Sync_cur_o !== 4'hF) begin errors++; $display("FAIL px_sync_cur got %h want f", Sync_cur_o); end
        checks++; if (nVDSYNC_o !== 1'b0) begin errors++; $display("FAIL px_nvdsync_lo got %b want 0", nVDSYNC_o); end
        step(1'b1, 7'h33);
        checks++; if (nVDSYNC_o !== 1'b1) begin errors++; $display("FAIL px_nvdsync_hi got %b want 1", nVDSYNC_o); end
        step(1'b1, 7'h00);
        checks++; if (vdata_valid_o !== 1'b0) begin errors++; $display("FAIL px_valid_early got %b want 0", vdata_valid_o); end
        step(1'b1, 7'h00);
        checks++; if (vdata_valid_o !== 1'b1) begin errors++; $display("FAIL px_valid got %b want 1", vdata_valid_o); end
        checks++; if (vdata_o !== exp) begin errors++; $display("FAIL px_vdata got %h want %h", vdata_o, exp); end
        step(1'b1, 7'h00);
        checks++; if (vdata_valid_o !== 1'b0) begin errors++; $display("FAIL px_valid_len got %b want 0", vdata_valid_o); end
        flush();
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL px_valid_count got %0d want 1", valid_cnt - v0); end
        checks++; if (err_pulses - p0 !== 0) begin errors++; $display("FAIL px_err_pulses got %0d want 0", err_pulses - p0); end
    endtask

    task automatic test_sync_pair();
        logic [24:0] exp;
        exp = {4'h5, 7'h04, 7'h05, 7'h06};
        step(1'b0, 7'h07);
        step(1'b1, 7'h01);
        step(1'b1, 7'h02);
        checks++; if (Sync_cur_o !== 4'h7 || Sync_pre_o !== 4'hF) begin
            errors++; $display("FAIL sp_first got pre %h cur %h want pre f cur 7", Sync_pre_o, Sync_cur_o); end
        step(1'b1, 7'h03);
        step(1'b0, 7'h05);
        step(1'b1, 7'h04);
        step(1'b1, 7'h05);
        checks++; if (nVDSYNC_o !== 1'b0) begin errors++; $display("FAIL sp_nvdsync_lo got %b want 0", nVDSYNC_o); end
        checks++; if (Sync_pre_o !== 4'h7) begin errors++; $display("FAIL sp_pre got %h want 7", Sync_pre_o); end
        checks++; if (Sync_cur_o !== 4'h5) begin errors++; $display("FAIL sp_cur got %h want 5", Sync_cur_o); end
        step(1'b1, 7'h06);
        checks++; if (nVDSYNC_o !== 1'b1) begin errors++; $display("FAIL sp_nvdsync_one_cycle got %b want 1", nVDSYNC_o); end
        checks++; if (Sync_pre_o !== 4'h7 || Sync_cur_o !== 4'h5) begin
            errors++; $display("FAIL sp_hold got pre %h cur %h want pre 7 cur 5", Sync_pre_o, Sync_cur_o); end
        step(1'b1, 7'h00);
        step(1'b1, 7'h00);
        checks++; if (vdata_valid_o !== 1'b1 || vdata_o !== exp) begin
            errors++; $display("FAIL sp_pixel got valid %b data %h want 1 %h", vdata_valid_o, vdata_o, exp); end
        flush();
    endtask

    task automatic test_abort();
        int v0, p0;
        logic [24:0] old_px, next_px;
        v0 = valid_cnt; p0 = err_pulses;
        old_px  = {4'h5, 7'h04, 7'h05, 7'h06};
        next_px = {4'h9, 7'h00, 7'h00, 7'h00};
        step(1'b0, 7'h03);
        step(1'b1, 7'h0A);
        step(1'b1, 7'h0B);
        step(1'b0, 7'h09);
        step(1'b1, 7'h00);
        step(1'b1, 7'h00);
        checks++; if (phase_err_o !== 1'b1) begin errors++; $display("FAIL ab_pulse got %b want 1", phase_err_o); end
        checks++; if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL ab_err_cnt got %h want 01", err_cnt_o); end
        checks++; if (vdata_valid_o !== 1'b0) begin errors++; $display("FAIL ab_valid got %b want 0", vdata_valid_o); end
        checks++; if (vdata_o !== old_px) begin errors++; $display("FAIL ab_vdata_hold got %h want %h", vdata_o, old_px); end
        checks++; if (Sync_pre_o !== 4'h3 || Sync_cur_o !== 4'h9) begin
            errors++; $display("FAIL ab_sync got pre %h cur %h want pre 3 cur 9", Sync_pre_o, Sync_cur_o); end
        step(1'b1, 7'h00);
        checks++; if (phase_err_o !== 1'b0) begin errors++; $display("FAIL ab_pulse_len got %b want 0", phase_err_o); end
        flush();
        checks++; if (err_pulses - p0 !== 1) begin errors++; $display("FAIL ab_pulse_count got %0d want 1", err_pulses - p0); end
        checks++; if (valid_cnt - v0 !== 1 || vdata_o !== next_px) begin
            errors++; $display("FAIL ab_resync got count %0d data %h want 1 %h", valid_cnt - v0, vdata_o, next_px); end
    endtask

    task automatic test_saturate();
        int p0;
        p0 = err_pulses;
        for (int i = 0; i < 200; i++) step(1'b0, 7'(i));
        step(1'b1, 7'h00);
        step(1'b1, 7'h00);
        checks++; if (err_cnt_o !== 8'd200) begin errors++; $display("FAIL sat_mid got %0d want 200", err_cnt_o); end
        for (int i = 0; i < 300; i++) step(1'b0, 7'(i));
        flush();
        checks++; if (err_cnt_o !== 8'hFF) begin errors++; $display("FAIL sat_cnt got %h want ff", err_cnt_o); end
        checks++; if (err_pulses - p0 !== 499) begin errors++; $display("FAIL sat_pulses got %0d want 499", err_pulses - p0); end
    endtask

    task automatic test_extra_bytes();
        int v0, p0;
        logic [24:0] exp;
        v0 = valid_cnt; p0 = err_pulses;
        exp = {4'h2, 7'h21, 7'h42, 7'h63};
        step(1'b0, 7'h02);
        step(1'b1, 7'h21);
        step(1'b1, 7'h42);
        step(1'b1, 7'h63);
        step(1'b1, 7'h7F);
        step(1'b1, 7'h7E);
        step(1'b1, 7'h7D);
        step(1'b0, 7'h01);
        step(1'b1, 7'h00);
        step(1'b1, 7'h00);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL ex_valid_count got %0d want 1", valid_cnt - v0); end
        checks++; if (err_pulses - p0 !== 0) begin errors++; $display("FAIL ex_err got %0d want 0", err_pulses - p0); end
        checks++; if (vdata_o !== exp) begin errors++; $display("FAIL ex_vdata got %h want %h", vdata_o, exp); end
        checks++; if (Sync_cur_o !== 4'h1 || Sync_pre_o !== 4'h2) begin
            errors++; $display("FAIL ex_sync got pre %h cur %h want pre 2 cur 1", Sync_pre_o, Sync_cur_o); end
        flush();
    endtask

    task automatic test_reset_mid();
        int v0, p0;
        logic [24:0] exp;
        exp = {4'h6, 7'h01, 7'h02, 7'h03};
        step(1'b0, 7'h04);
        step(1'b1, 7'h10);
        step(1'b1, 7'h20);
        step(1'b1, 7'h30);
        #1;
        nRST = 1'b0;
        #1;
        checks++; if (nVDSYNC_o !== 1'b1 || Sync_pre_o !== 4'hF || Sync_cur_o !== 4'hF) begin
            errors++; $display("FAIL rm_sync got n %b pre %h cur %h want 1 f f", nVDSYNC_o, Sync_pre_o, Sync_cur_o); end
        checks++; if (vdata_o !== 25'h0 || vdata_valid_o !== 1'b0) begin
            errors++; $display("FAIL rm_vdata got %h valid %b want 0 0", vdata_o, vdata_valid_o); end
        checks++; if (err_cnt_o !== 8'h00 || phase_err_o !== 1'b0) begin
            errors++; $display("FAIL rm_err got cnt %h pulse %b want 00 0", err_cnt_o, phase_err_o); end
        step(1'b1, 7'h00);
        step(1'b1, 7'h00);
        @(negedge VCLK);
        nRST = 1'b1;
        v0 = valid_cnt; p0 = err_pulses;
        step(1'b0, 7'h06);
        step(1'b1, 7'h01);
        step(1'b1, 7'h02);
        step(1'b1, 7'h03);
        flush();
        checks++; if (valid_cnt - v0 !== 1 || vdata_o !== exp) begin
            errors++; $display("FAIL rm_pixel got count %0d data %h want 1 %h", valid_cnt - v0, vdata_o, exp); end
        checks++; if (err_cnt_o !== 8'h00 || err_pulses - p0 !== 0) begin
            errors++; $display("FAIL rm_no_err got cnt %h pulses %0d want 00 0", err_cnt_o, err_pulses - p0); end
        checks++; if (Sync_pre_o !== 4'hF || Sync_cur_o !== 4'h6) begin
            errors++; $display("FAIL rm_sync_after got pre %h cur %h want f 6", Sync_pre_o, Sync_cur_o); end
    endtask

    initial begin
        nRST    = 1'b0;
        nVDSYNC = 1'b1;
        D_i     = 7'h00;
        test_reset();
        test_pixel();
        test_sync_pair();
        test_abort();
        test_saturate();
        test_extra_bytes();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
